// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sample width and the signed sample type.
package fir_pkg;
    localparam int SAMPLE_W = 9;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Generic first-word-fall-through FIFO. The head entry is presented combinationally,
// and the last popped word is held on data_o while the FIFO is empty.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic signed [WIDTH-1:0]   data_i,
    output logic signed [WIDTH-1:0]   data_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]              wrPtr_q, wrPtr_d;
    logic [AW:0]              rdPtr_q, rdPtr_d;
    logic signed [WIDTH-1:0]  hold_q, hold_d;
    logic signed [WIDTH-1:0]  mem_q [DEPTH];
    logic                     doPush, doPop;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign level_o = wrPtr_q - rdPtr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = empty_o ? hold_q : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        hold_d  = hold_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
            hold_d  = mem_q[rdPtr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            hold_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/fir_decim_fifo.sv
// FIR output stage: keeps one of every DECIM samples and buffers them in a FWFT FIFO.
// Define FIR_DECIM_DROP_CNT_EN to add the saturating drop_cnt port and counter.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
`ifdef FIR_DECIM_DROP_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   in_data,
    input  logic                      sync,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      overflow,
    input  logic                      clr_ovf
`ifdef FIR_DECIM_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]          drop_cnt
`endif
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_SYNC = (DECIM > 1) ? PH_W'(1) : '0;

    logic [PH_W-1:0] phase_q, phase_d;
    logic            overflow_q, overflow_d;
    logic            keep, pop, drop, empty;

    assign keep      = in_valid && (sync || (phase_q == '0));
    assign pop       = out_ready && !empty;
    assign drop      = keep && full && !pop;
    assign out_valid = !empty;
    assign overflow  = overflow_q;

    fir_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (keep),
        .pop_i   (out_ready),
        .data_i  (in_data),
        .data_o  (out_data),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // A sync accompanying a sample keeps it and restarts counting right after it.
    always_comb begin
        phase_d    = phase_q;
        overflow_d = overflow_q;
        if (in_valid && sync) begin
            phase_d = PH_SYNC;
        end else if (in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end else if (sync) begin
            phase_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FIR_DECIM_DROP_CNT_EN
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (drop) begin
            if (clr_ovf) begin
                dropCnt_d = CNT_W'(1);
            end else if (!(&dropCnt_q)) begin
                dropCnt_d = dropCnt_q + 1'b1;
            end
        end else if (clr_ovf) begin
            dropCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    assign drop_cnt = dropCnt_q;
`endif
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: two instances (DECIM = 4 and DECIM = 1) checked every cycle
// against a queue-based reference model, plus directed scenarios with literal expectations.
module tb_fir_decim_fifo;
    import fir_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivV   [2];
    logic        syV   [2];
    logic        rdyV  [2];
    logic        clrV  [2];
    sample_t     dV    [2];
    sample_t     odV   [2];
    logic        validV[2];
    logic [3:0]  lvV   [2];
    logic        fullV [2];
    logic        ovfV  [2];
`ifdef FIR_DECIM_DROP_CNT_EN
    logic [15:0] dcV   [2];
`endif

    sample_t mQ   [2][$];
    sample_t rxQ  [2][$];
    int      mPhase[2];
    bit      mOvf  [2];
    int      mCnt  [2];
    int      maxLvl[2];
    int      checks = 0;
    int      errors = 0;
    bit      cmpEn  = 1'b0;

    always #5 clk = ~clk;

    fir_decim_fifo #(.DECIM(4), .DEPTH(DEPTH)) u4 (
        .clk(clk), .rst(rst), .in_valid(ivV[0]), .in_data(dV[0]), .sync(syV[0]),
        .out_valid(validV[0]), .out_ready(rdyV[0]), .out_data(odV[0]), .level(lvV[0]),
        .full(fullV[0]), .overflow(ovfV[0]), .clr_ovf(clrV[0])
`ifdef FIR_DECIM_DROP_CNT_EN
        , .drop_cnt(dcV[0])
`endif
    );

    fir_decim_fifo #(.DECIM(1), .DEPTH(DEPTH)) u1 (
        .clk(clk), .rst(rst), .in_valid(ivV[1]), .in_data(dV[1]), .sync(syV[1]),
        .out_valid(validV[1]), .out_ready(rdyV[1]), .out_data(odV[1]), .level(lvV[1]),
        .full(fullV[1]), .overflow(ovfV[1]), .clr_ovf(clrV[1])
`ifdef FIR_DECIM_DROP_CNT_EN
        , .drop_cnt(dcV[1])
`endif
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour: pop first, then a kept sample goes in if there is room.
    task automatic modelStep(input int i);
        int dec;
        bit pop, keep, drop;
        dec = (i == 0) ? 4 : 1;
        if (rst) begin
            mQ[i].delete();
            mPhase[i] = 0;
            mOvf[i]   = 1'b0;
            mCnt[i]   = 0;
            return;
        end
        pop  = (mQ[i].size() > 0) && rdyV[i];
        keep = ivV[i] && (syV[i] || mPhase[i] == 0);
        drop = 1'b0;
        if (pop) void'(mQ[i].pop_front());
        if (keep) begin
            if (mQ[i].size() < DEPTH) mQ[i].push_back(dV[i]);
            else drop = 1'b1;
        end
        if (ivV[i]) mPhase[i] = syV[i] ? (1 % dec) : (mPhase[i] + 1) % dec;
        else if (syV[i]) mPhase[i] = 0;
        if (drop) begin
            mOvf[i] = 1'b1;
            mCnt[i] = clrV[i] ? 1 : ((mCnt[i] < 65535) ? mCnt[i] + 1 : mCnt[i]);
        end else if (clrV[i]) begin
            mOvf[i] = 1'b0;
            mCnt[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) modelStep(i);
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("out_valid[%0d]", i), int'(validV[i]), int'(mQ[i].size() > 0));
                checkOutput($sformatf("level[%0d]", i), int'(lvV[i]), mQ[i].size());
                checkOutput($sformatf("full[%0d]", i), int'(fullV[i]), int'(mQ[i].size() == DEPTH));
                checkOutput($sformatf("overflow[%0d]", i), int'(ovfV[i]), int'(mOvf[i]));
`ifdef FIR_DECIM_DROP_CNT_EN
                checkOutput($sformatf("drop_cnt[%0d]", i), int'(dcV[i]), mCnt[i]);
`endif
                if (mQ[i].size() > 0)
                    checkOutput($sformatf("out_data[%0d]", i), int'(odV[i]), int'(mQ[i][0]));
                if (validV[i] && rdyV[i]) rxQ[i].push_back(odV[i]);
                if (int'(lvV[i]) > maxLvl[i]) maxLvl[i] = int'(lvV[i]);
            end
        end
    end

    task automatic applyStimulus(input int i, input bit iv, input int d, input bit sy,
                                 input bit rdy, input bit clr);
        for (int k = 0; k < 2; k++) begin
            ivV[k]  = 1'b0;
            syV[k]  = 1'b0;
            clrV[k] = 1'b0;
        end
        ivV[i]  = iv;
        dV[i]   = sample_t'(d);
        syV[i]  = sy;
        rdyV[i] = rdy;
        clrV[i] = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRx(input int i, input string name, input int exp[$]);
        checkOutput({name, " count"}, rxQ[i].size(), exp.size());
        for (int k = 0; k < exp.size() && k < rxQ[i].size(); k++)
            checkOutput($sformatf("%s[%0d]", name, k), int'(rxQ[i][k]), exp[k]);
    endtask

    initial begin
        int expRx[$];
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ivV[i] = 0; syV[i] = 0; rdyV[i] = 0; clrV[i] = 0; dV[i] = '0;
            maxLvl[i] = 0; mPhase[i] = 0; mOvf[i] = 0; mCnt[i] = 0;
        end
        @(posedge clk); #1;
        cmpEn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset out_valid", int'(validV[i]), 0);
            checkOutput("reset level", int'(lvV[i]), 0);
            checkOutput("reset full", int'(fullV[i]), 0);
            checkOutput("reset overflow", int'(ovfV[i]), 0);
            checkOutput("reset out_data", int'(odV[i]), 0);
`ifdef FIR_DECIM_DROP_CNT_EN
            checkOutput("reset drop_cnt", int'(dcV[i]), 0);
`endif
        end
        rst = 1'b0;

        // DECIM = 4 streaming with out_ready held high.
        rxQ[0].delete();
        maxLvl[0] = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, k, 0, 1, 0);
            checkOutput($sformatf("decim4 valid after %0d", k), int'(validV[0]), int'(k % 4 == 0));
            if (k % 4 == 0) checkOutput("decim4 latency data", int'(odV[0]), k);
        end
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
        expRx = '{0, 4, 8};
        checkRx(0, "decim4 rx", expRx);
        checkOutput("decim4 max level", maxLvl[0], 1);

        // DECIM = 1 overfill, clear, push-with-pop on a full FIFO, then drain.
        rxQ[1].delete();
        for (int k = 0; k < 10; k++) applyStimulus(1, 1, -256 + k, 0, 0, 0);
        checkOutput("overfill level", int'(lvV[1]), 8);
        checkOutput("overfill full", int'(fullV[1]), 1);
        checkOutput("overfill overflow", int'(ovfV[1]), 1);
        checkOutput("overfill head", int'(odV[1]), -256);
`ifdef FIR_DECIM_DROP_CNT_EN
        checkOutput("overfill drop_cnt", int'(dcV[1]), 2);
`endif
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("clr overflow", int'(ovfV[1]), 0);
        applyStimulus(1, 1, 100, 0, 1, 0);
        checkOutput("full push+pop level", int'(lvV[1]), 8);
        checkOutput("full push+pop overflow", int'(ovfV[1]), 0);
        checkOutput("full push+pop head", int'(odV[1]), -255);
        repeat (9) applyStimulus(1, 0, 0, 0, 1, 0);
        expRx = '{-256, -255, -254, -253, -252, -251, -250, -249, 100};
        checkRx(1, "drain rx", expRx);

        // Drop coincident with clr_ovf, then clr_ovf alone.
        for (int k = 0; k < 8; k++) applyStimulus(1, 1, k, 0, 0, 0);
        applyStimulus(1, 1, 50, 0, 0, 1);
        checkOutput("clr+drop overflow", int'(ovfV[1]), 1);
`ifdef FIR_DECIM_DROP_CNT_EN
        checkOutput("clr+drop drop_cnt", int'(dcV[1]), 1);
`endif
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("clr alone overflow", int'(ovfV[1]), 0);
`ifdef FIR_DECIM_DROP_CNT_EN
        checkOutput("clr alone drop_cnt", int'(dcV[1]), 0);
`endif
        repeat (9) applyStimulus(1, 0, 0, 0, 1, 0);

        // Sync with a sample at phase 2, then sync on its own.
        rxQ[0].delete();
        for (int v = 5; v <= 12; v++) applyStimulus(0, 1, v, v == 7, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 20, 0, 1, 0);
        applyStimulus(0, 1, 21, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);
        expRx = '{5, 7, 11, 20};
        checkRx(0, "sync rx", expRx);

        // Reset with data buffered; the sample in the reset cycle is lost.
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 30 + k, 1, 0, 0);
        checkOutput("pre-reset level", int'(lvV[0]), 5);
        checkOutput("pre-reset valid", int'(validV[0]), 1);
        rst = 1'b1;
        applyStimulus(0, 1, 99, 1, 0, 0);
        rst = 1'b0;
        checkOutput("post-reset valid", int'(validV[0]), 0);
        checkOutput("post-reset level", int'(lvV[0]), 0);
        applyStimulus(0, 1, 42, 0, 1, 0);
        checkOutput("after reset valid", int'(validV[0]), 1);
        checkOutput("after reset data", int'(odV[0]), 42);
        checkOutput("after reset level", int'(lvV[0]), 1);

        // Randomized traffic on both instances; first half mostly back-pressured.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                ivV[i]  = ($urandom_range(0, 3) != 0);
                dV[i]   = sample_t'($urandom);
                syV[i]  = ($urandom_range(0, 15) == 0);
                rdyV[i] = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
                clrV[i] = ($urandom_range(0, 31) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ivV[i] = 0; syV[i] = 0; clrV[i] = 0; rdyV[i] = 1;
        end
        repeat (12) begin
            @(posedge clk); #1;
        end
        checkOutput("final level u4", int'(lvV[0]), 0);
        checkOutput("final level u1", int'(lvV[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
